lcd_fb_scanner: RTL and testbench
=================================

Name: lcd_fb_scanner

Overview:
- Downstream consumer of the LCD framebuffer's 1-bit-wide read port: 16384 × 1 bit, 14-bit address, synchronous read with 1-cycle latency gated by read enable.
- Walks the framebuffer linearly once per frame, packs 8 consecutive pixels MSB-first into a byte, and hands bytes to the LCD bus interface over a valid/ready handshake.
- Stalls reads under backpressure; never drops or duplicates a pixel.

Parameters:
- H_PIXELS, 128, pixels per line; multiple of 8.
- V_LINES, 128, lines per frame; H_PIXELS*V_LINES ≤ 2^FB_ADDR_W.
- FB_ADDR_W, 14, framebuffer address width.

Ports:
- clk  in  1  single clock; drives the framebuffer read port as well.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a frame when idle.
- cont  in  1  1 = automatic restart after each frame.
- fb_en  out  1  framebuffer read enable.
- fb_addr  out  FB_ADDR_W  framebuffer read address.
- fb_data  in  1  framebuffer read data; valid 1 cycle after fb_en.
- px_byte  out  8  packed pixels; bit 7 = lowest address.
- px_valid  out  1  px_byte valid.
- px_ready  in  1  consumer accepts when px_valid & px_ready.
- px_sof  out  1  qualifies first byte of frame (with px_valid).
- px_eol  out  1  qualifies last byte of a line (with px_valid).
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after last byte accepted.

Behaviour:
- Reset (async, rst_n=0): state IDLE; fb_en=0, fb_addr=0, px_byte=0, px_valid=0, px_sof=0, px_eol=0, busy=0, frame_done=0; shift register and counters cleared. Applies mid-frame as well: no partial byte survives, no frame_done.
- States:
  - IDLE: start=1 → FETCH; fb_addr=0, busy=1 from the next cycle. start while busy is ignored.
  - FETCH: issue one read per cycle (fb_en=1, fb_addr increments by 1 after each issue).
  - HOLD: fb_en=0; waits for the output register to free.
  - DRAIN: all reads issued; waits for the last byte to be accepted.
- Read/return alignment: a bit issued in cycle t is shifted in at t+1. A 3-bit bit counter tracks returned bits.
- Byte completion: on the cycle the 8th bit returns:
  - If px_valid=0 or px_ready=1, the byte loads into the output register (px_valid=1 next cycle).
  - Otherwise it stays in the shift register and the state goes to HOLD.
  - No read is issued in a completion cycle unless the load is possible in that same cycle. This guarantees no read is in flight on entry to HOLD.
- HOLD exit: when px_ready=1 the pending byte loads and the state returns to FETCH, or to DRAIN if all addresses are issued.
- Throughput: 1 pixel per clk, 1 byte per 8 clk when px_ready is held high. First px_valid appears 9 cycles after the start pulse.
- px_valid/px_byte/px_sof/px_eol are stable while px_valid=1 and px_ready=0.
- px_sof=1 on the byte from addresses 0..7. px_eol=1 when the byte's last address mod H_PIXELS = H_PIXELS-1.
- Wrap/end: after issuing address H_PIXELS*V_LINES-1, no further reads; go to DRAIN.
- On acceptance of the final byte: frame_done=1 for 1 cycle. Then:
  - cont=1: restart directly in FETCH at address 0, busy stays 1.
  - cont=0: go to IDLE, busy=0.
- start coincident with the final-byte acceptance and cont=0: the new frame begins (treated as restart).
- Address counter width FB_ADDR_W, unsigned. With defaults, the last address 16383 is the terminal count and the counter does not overflow.

Optional Feature:
- Macro LCD_FB_INVERT_EN.
- Defined: adds input port invert (1 bit), sampled at frame start and held for the whole frame. When set, each pixel is XORed with 1 before packing.
- Undefined: no invert port; pixels pass unmodified.

Decomposition:
- Package lcd_pkg holds:
  - H_PIXELS, V_LINES and FB_ADDR_W defaults.
  - The state enum (IDLE, FETCH, HOLD, DRAIN).
  - The localparam FRAME_PIXELS.
- One sub-module, lcd_px_pack: 8-bit shift register, bit counter, output register and valid/ready logic. It exposes a can_issue signal to the scanner FSM.

Test Plan:
- Framebuffer preloaded 0xA5 pattern (bits 10100101 repeating), px_ready=1, pulse start → 2048 bytes all 0xA5; first px_valid 9 cycles after start; frame_done 1 cycle after last accept; busy falls.
- Checkerboard per line (line y even = 0x55, odd = 0xAA), px_ready toggling randomly 50% → byte sequence exact, no gaps or duplicates; fb_en=0 throughout every HOLD; px_sof only on byte 0; px_eol on bytes 15, 31, …, 2047.
- px_ready=0 for 40 cycles after first valid → px_byte held constant; exactly 8 reads issued for the held byte, then fb_en stays 0 until the stall ends.
- rst_n low at byte 700 mid-frame, then release and pulse start → outputs reset immediately; new frame starts at address 0 with px_sof=1 and no stale bits.
- cont=1 for 3 frames → frame_done pulses exactly 3 times; address wraps 16383→0 with busy held 1; start pulses during a frame ignored.
- LCD_FB_INVERT_EN defined, invert=1, framebuffer all 0 → all bytes 0xFF; invert toggled mid-frame has no effect until the next frame.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared defaults and state type for the LCD framebuffer scanner
//
// Purpose: default geometry of the framebuffer walk and the scanner state
// encoding, imported by lcd_px_pack and lcd_fb_scanner.
// Ports: none (package).
package lcd_pkg;

  localparam int DEF_H_PIXELS  = 128;
  localparam int DEF_V_LINES   = 128;
  localparam int DEF_FB_ADDR_W = 14;
  localparam int FRAME_PIXELS  = DEF_H_PIXELS * DEF_V_LINES;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } scan_state_e;

endpackage

// File: rtl/lcd_px_pack.sv
// rtl/lcd_px_pack.sv - 1-bit to byte packer with output register and valid/ready
//
// Purpose: shifts returning framebuffer bits into an 8-bit register
// (first bit ends up in bit 7), moves completed bytes into the output register
// and tells the scanner whether a read may be issued this cycle.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rd_issue_i           a framebuffer read is issued this cycle
//   rd_addr_i            address of that read
//   pix_i                returning pixel (valid one cycle after rd_issue_i)
//   px_ready_i           consumer ready
//   can_issue_o          a read may be issued this cycle
//   frame_end_o          final byte of the frame is accepted this cycle
//   px_byte_o/px_valid_o/px_sof_o/px_eol_o  output byte stream
module lcd_px_pack
  import lcd_pkg::*;
#(
  parameter int H_PIXELS  = DEF_H_PIXELS,
  parameter int N_PIXELS  = FRAME_PIXELS,
  parameter int FB_ADDR_W = DEF_FB_ADDR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rd_issue_i,
  input  logic [FB_ADDR_W-1:0] rd_addr_i,
  input  logic                 pix_i,
  input  logic                 px_ready_i,
  output logic                 can_issue_o,
  output logic                 frame_end_o,
  output logic [7:0]           px_byte_o,
  output logic                 px_valid_o,
  output logic                 px_sof_o,
  output logic                 px_eol_o
);

  localparam logic [FB_ADDR_W-1:0] SOF_ADDR  = FB_ADDR_W'(7);
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(N_PIXELS - 1);
  localparam logic [FB_ADDR_W-1:0] H_LEN     = FB_ADDR_W'(H_PIXELS);
  localparam logic [FB_ADDR_W-1:0] H_LAST    = FB_ADDR_W'(H_PIXELS - 1);

  // ret_q marks a bit arriving on pix_i this cycle; ret_addr_q is its address.
  // While a byte is pending no reads are issued, so ret_addr_q still holds
  // the last address of the pending byte when it finally loads.
  logic                 ret_q, ret_d;
  logic [FB_ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic [7:0]           sr_q, sr_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [7:0]           out_byte_q, out_byte_d;
  logic                 out_vld_q, out_vld_d;
  logic                 out_sof_q, out_sof_d;
  logic                 out_eol_q, out_eol_d;
  logic                 out_last_q, out_last_d;

  logic [7:0] shifted;
  logic       complete;
  logic       out_free;
  logic       load_new;
  logic       load_pend;
  logic       accept;

  always_comb begin
    shifted   = {sr_q[6:0], pix_i};
    complete  = ret_q && (cnt_q == 3'd7);
    out_free  = !out_vld_q || px_ready_i;
    load_new  = complete && out_free;
    load_pend = pend_q && px_ready_i;
    accept    = out_vld_q && px_ready_i;

    // A completion that cannot load blocks the read in the same cycle, so
    // nothing is in flight once the byte is parked in the shift register.
    can_issue_o = !pend_q && !(complete && !out_free);
    frame_end_o = accept && out_last_q;

    ret_d      = rd_issue_i;
    ret_addr_d = rd_issue_i ? rd_addr_i : ret_addr_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    out_byte_d = out_byte_q;
    out_vld_d  = out_vld_q;
    out_sof_d  = out_sof_q;
    out_eol_d  = out_eol_q;
    out_last_d = out_last_q;

    if (ret_q) begin
      sr_d  = shifted;
      cnt_d = cnt_q + 3'd1;
    end

    if (complete && !out_free) begin
      pend_d = 1'b1;
    end else if (load_pend) begin
      pend_d = 1'b0;
    end

    if (accept) begin
      out_vld_d = 1'b0;
    end

    if (load_new || load_pend) begin
      out_byte_d = load_new ? shifted : sr_q;
      out_vld_d  = 1'b1;
      out_sof_d  = (ret_addr_q == SOF_ADDR);
      out_eol_d  = ((ret_addr_q % H_LEN) == H_LAST);
      out_last_d = (ret_addr_q == LAST_ADDR);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ret_q      <= 1'b0;
      ret_addr_q <= '0;
      sr_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      out_byte_q <= '0;
      out_vld_q  <= 1'b0;
      out_sof_q  <= 1'b0;
      out_eol_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      ret_q      <= ret_d;
      ret_addr_q <= ret_addr_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      out_byte_q <= out_byte_d;
      out_vld_q  <= out_vld_d;
      out_sof_q  <= out_sof_d;
      out_eol_q  <= out_eol_d;
      out_last_q <= out_last_d;
    end
  end

  assign px_byte_o  = out_byte_q;
  assign px_valid_o = out_vld_q;
  assign px_sof_o   = out_sof_q;
  assign px_eol_o   = out_eol_q;

endmodule

// File: rtl/lcd_fb_scanner.sv
// rtl/lcd_fb_scanner.sv - framebuffer scanner: linear 1-bit reads packed into a byte stream
//
// Purpose: walks the framebuffer once per frame, one read per cycle while the
// packer can take data, and streams packed bytes to the LCD bus interface.
// Optional macro LCD_FB_INVERT_EN adds an invert input sampled at frame start.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, cont           frame start pulse, continuous-restart enable
//   invert                (LCD_FB_INVERT_EN only) invert pixels of next frame
//   fb_en, fb_addr        framebuffer read request
//   fb_data               framebuffer read data, one cycle after fb_en
//   px_byte, px_valid, px_ready, px_sof, px_eol   byte stream
//   busy, frame_done      frame in progress, final-byte-accepted pulse
module lcd_fb_scanner
  import lcd_pkg::*;
#(
  parameter int H_PIXELS  = DEF_H_PIXELS,
  parameter int V_LINES   = DEF_V_LINES,
  parameter int FB_ADDR_W = DEF_FB_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cont,
`ifdef LCD_FB_INVERT_EN
  input  logic                 invert,
`endif
  output logic                 fb_en,
  output logic [FB_ADDR_W-1:0] fb_addr,
  input  logic                 fb_data,
  output logic [7:0]           px_byte,
  output logic                 px_valid,
  input  logic                 px_ready,
  output logic                 px_sof,
  output logic                 px_eol,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int FRAME_PX = H_PIXELS * V_LINES;
  localparam logic [FB_ADDR_W-1:0] ADDR_LAST = FB_ADDR_W'(FRAME_PX - 1);

  scan_state_e          state_q, state_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic                 all_issued_q, all_issued_d;
  logic                 done_q, done_d;
  logic                 can_issue;
  logic                 frame_end;
  logic                 pix;

`ifdef LCD_FB_INVERT_EN
  logic inv_q, inv_d;
  assign pix = fb_data ^ inv_q;
`else
  assign pix = fb_data;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    all_issued_d = all_issued_q;
    done_d       = frame_end;
    fb_en        = 1'b0;
`ifdef LCD_FB_INVERT_EN
    inv_d        = inv_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FETCH;
          addr_d       = '0;
          all_issued_d = 1'b0;
`ifdef LCD_FB_INVERT_EN
          inv_d        = invert;
`endif
        end
      end

      FETCH: begin
        if (can_issue) begin
          fb_en = 1'b1;
          if (addr_q == ADDR_LAST) begin
            // Terminal count: explicit clear keeps non power-of-two frames correct.
            addr_d       = '0;
            all_issued_d = 1'b1;
            state_d      = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        // The pending byte loads in the packer in this same cycle.
        if (px_ready) begin
          state_d = all_issued_q ? DRAIN : FETCH;
        end
      end

      DRAIN: begin
        if (frame_end) begin
          if (cont || start) begin
            state_d      = FETCH;
            addr_d       = '0;
            all_issued_d = 1'b0;
`ifdef LCD_FB_INVERT_EN
            inv_d        = invert;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      all_issued_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef LCD_FB_INVERT_EN
      inv_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      all_issued_q <= all_issued_d;
      done_q       <= done_d;
`ifdef LCD_FB_INVERT_EN
      inv_q        <= inv_d;
`endif
    end
  end

  lcd_px_pack #(
    .H_PIXELS  (H_PIXELS),
    .N_PIXELS  (FRAME_PX),
    .FB_ADDR_W (FB_ADDR_W)
  ) u_pack (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_issue_i  (fb_en),
    .rd_addr_i   (addr_q),
    .pix_i       (pix),
    .px_ready_i  (px_ready),
    .can_issue_o (can_issue),
    .frame_end_o (frame_end),
    .px_byte_o   (px_byte),
    .px_valid_o  (px_valid),
    .px_sof_o    (px_sof),
    .px_eol_o    (px_eol)
  );

  assign fb_addr    = addr_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_lcd_fb_scanner.sv
// tb/tb_lcd_fb_scanner.sv - directed self-checking bench for lcd_fb_scanner
module tb_lcd_fb_scanner;

  localparam int H   = 32;
  localparam int V   = 16;
  localparam int AW  = 9;
  localparam int NPX = H * V;
  localparam int NBY = NPX / 8;
  localparam int BPL = H / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          fb_en;
  logic [AW-1:0] fb_addr;
  logic          fb_data = 1'b0;
  logic [7:0]    px_byte;
  logic          px_valid;
  logic          px_ready = 1'b0;
  logic          px_sof;
  logic          px_eol;
  logic          busy;
  logic          frame_done;
`ifdef LCD_FB_INVERT_EN
  logic          invert = 1'b0;
`endif

  lcd_fb_scanner #(.H_PIXELS(H), .V_LINES(V), .FB_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
`ifdef LCD_FB_INVERT_EN
    .invert     (invert),
`endif
    .fb_en      (fb_en),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .px_byte    (px_byte),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_sof     (px_sof),
    .px_eol     (px_eol),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic fb_mem [NPX];
  always @(posedge clk) if (fb_en) fb_data <= fb_mem[fb_addr];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ready driver: 0 = always ready, 1 = random 50%, 2 = held low
  int ready_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       px_ready = 1'b1;
      1:       px_ready = 1'($urandom_range(0, 1));
      default: px_ready = 1'b0;
    endcase
  end

  logic [7:0] inv_mask = 8'h00;

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = fb_mem[8*k + i];
    return b ^ inv_mask;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc++;

  int rd_cnt = 0, acc_cnt = 0, rd_base = 0, acc_base = 0;
  int fd_cnt = 0, fd_cyc = 0, last_acc_cyc = 0;
  int rd_viol = 0, stab_viol = 0, mon_k = 0;
  logic       hold_v = 1'b0;
  logic [9:0] held = '0;

  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (!rst_n) hold_v = 1'b0;
    else begin
      if (hold_v && (px_valid !== 1'b1 || {px_byte, px_sof, px_eol} !== held)) stab_viol++;
      hold_v = px_valid && !px_ready;
      held   = {px_byte, px_sof, px_eol};
    end
    if (fb_en) rd_cnt++;
    if (px_valid && px_ready) begin
      mon_k = (acc_cnt - acc_base) % NBY;
      check($sformatf("byte%0d", mon_k), 32'(px_byte), 32'(exp_byte(mon_k)));
      check($sformatf("sof%0d", mon_k), 32'(px_sof), 32'(mon_k == 0));
      check($sformatf("eol%0d", mon_k), 32'(px_eol), 32'((mon_k % BPL) == BPL - 1));
      if (mon_k == NBY - 1) last_acc_cyc = cyc;
      acc_cnt++;
    end
    if ((rd_cnt - rd_base) > 8 * (acc_cnt - acc_base) + 16) rd_viol++;
  end

  task automatic fill(input int kind);
    logic [7:0] a5;
    a5 = 8'hA5;
    for (int i = 0; i < NPX; i++) begin
      case (kind)
        0:       fb_mem[i] = a5[7 - (i % 8)];
        1:       fb_mem[i] = 1'(((i / H) + (i % H)) % 2);
        2:       fb_mem[i] = 1'($urandom_range(0, 1));
        default: fb_mem[i] = 1'b0;
      endcase
    end
  endtask

  task automatic new_frame_base();
    rd_base  = rd_cnt;
    acc_base = acc_cnt;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int f0, n;
    f0 = fd_cnt;
    n  = 0;
    while (fd_cnt == f0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_done"}, 32'(fd_cnt != f0), 32'd1);
    check({tag, "_nbytes"}, 32'(acc_cnt - acc_base), 32'(NBY));
  endtask

  task automatic wait_bytes(input string tag, input int nb);
    int n;
    n = 0;
    while ((acc_cnt - acc_base) < nb && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_reached"}, 32'((acc_cnt - acc_base) >= nb), 32'd1);
  endtask

  initial begin
    int lat, fd0, chg, drops, wraps, n;
    logic [AW-1:0] prev;
    logic [7:0] held0;

    // reset values
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_en", 32'(fb_en), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_px_byte", 32'(px_byte), 32'd0);
    check("rst_px_valid", 32'(px_valid), 32'd0);
    check("rst_px_sof", 32'(px_sof), 32'd0);
    check("rst_px_eol", 32'(px_eol), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // 0xA5 frame, ready always high
    ready_mode = 0;
    new_frame_base();
    fd0 = fd_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    while (!px_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("first_valid_lat", 32'(lat), 32'd9);
    wait_done("a5", 2000);
    check("a5_done_lat", 32'(fd_cyc - last_acc_cyc), 32'd1);
    check("a5_busy_fall", 32'(busy), 32'd0);
    check("a5_reads", 32'(rd_cnt - rd_base), 32'(NPX));
    repeat (4) @(negedge clk);
    #1;
    check("a5_done_pulses", 32'(fd_cnt - fd0), 32'd1);

    // checkerboard, random backpressure
    fill(1);
    ready_mode = 1;
    new_frame_base();
    pulse_start();
    wait_done("chk", 4000);
    check("chk_read_bound", 32'(rd_viol), 32'd0);
    check("chk_stable", 32'(stab_viol), 32'd0);

    // 40-cycle stall right after first valid
    fill(2);
    ready_mode = 2;
    repeat (2) @(negedge clk);
    new_frame_base();
    pulse_start();
    n = 0;
    while (!px_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("stall_valid", 32'(px_valid), 32'd1);
    held0 = px_byte;
    check("stall_first", 32'(px_byte), 32'(exp_byte(0)));
    chg = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (px_byte !== held0 || px_valid !== 1'b1) chg++;
    end
    check("stall_held", 32'(chg), 32'd0);
    check("stall_reads", 32'(rd_cnt - rd_base), 32'd16);
    check("stall_fb_en", 32'(fb_en), 32'd0);
    ready_mode = 0;
    wait_done("stall", 2000);

    // asynchronous reset mid-frame
    fill(2);
    new_frame_base();
    pulse_start();
    wait_bytes("mid", 20);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(px_valid), 32'd0);
    check("mid_rst_byte", 32'(px_byte), 32'd0);
    check("mid_rst_fb_en", 32'(fb_en), 32'd0);
    check("mid_rst_addr", 32'(fb_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    fd0 = fd_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("mid_no_done", 32'(fd_cnt - fd0), 32'd0);
    check("mid_idle", 32'(busy), 32'd0);
    new_frame_base();
    pulse_start();
    wait_done("mid", 2000);

    // continuous mode, three frames, stray starts ignored
    fill(2);
    cont = 1'b1;
    new_frame_base();
    fd0 = fd_cnt;
    pulse_start();
    drops = 0;
    wraps = 0;
    prev  = '0;
    n     = 0;
    while (n < 3000) begin
      @(negedge clk);
      #1;
      n++;
      start = (n == 100 || n == 300 || n == 1300);
      if (fd_cnt - fd0 >= 3) break;
      if (fd_cnt - fd0 == 2) cont = 1'b0;
      if (!busy) drops++;
      if (fb_en) begin
        if (fb_addr == '0 && prev == AW'(NPX - 1)) wraps++;
        prev = fb_addr;
      end
    end
    start = 1'b0;
    cont  = 1'b0;
    check("cont_frames", 32'(fd_cnt - fd0), 32'd3);
    check("cont_busy_held", 32'(drops), 32'd0);
    check("cont_wraps", 32'(wraps), 32'd2);
    check("cont_bytes", 32'(acc_cnt - acc_base), 32'(3 * NBY));
    repeat (3) @(negedge clk);
    #1;
    check("cont_idle", 32'(busy), 32'd0);

`ifdef LCD_FB_INVERT_EN
    // invert sampled at frame start only
    fill(3);
    invert   = 1'b1;
    inv_mask = 8'hFF;
    new_frame_base();
    pulse_start();
    wait_bytes("inv", 10);
    invert = 1'b0;
    wait_done("inv1", 2000);
    inv_mask = 8'h00;
    new_frame_base();
    pulse_start();
    wait_done("inv0", 2000);
`endif

    check("read_bound", 32'(rd_viol), 32'd0);
    check("stable", 32'(stab_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached (checks %0d)", n_chk);
    $fatal(1);
  end

endmodule
